seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Display scan controller for the Pmod two-digit 7-segment display fed by the AXI_7SEG register bank. It time-multiplexes both digits over one segment bus and one digit-select line. Each digit change is preceded by a blanking gap to prevent ghosting, and brightness is set by PWM. Configuration is double-buffered: a new value takes effect only at a frame boundary, so the display never tears.

Parameters:
REFRESH_DIV, 100000, ACLK cycles per digit slot (1 ms at 100 MHz); must be >= 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with segments forced off; must be < REFRESH_DIV.

Ports:
ACLK  in  1  system clock
ARESET  in  1  asynchronous, active-high reset
enable  in  1  1 = scanning; 0 = display dark
brightness  in  4  PWM duty = brightness/15 during SHOW
cfg_valid  in  1  config update request
cfg_ready  out  1  config accept (valid & ready = accept)
cfg_data  in  16  [15] raw flag; hex mode: [3:0] digit0, [7:4] digit1; raw mode: [6:0] digit0 segs, [14:8] digit1 segs
seg_o  out  7  segments, active-high, [0]=a .. [6]=g
sel_o  out  1  digit select; 0 = digit0 (right), 1 = digit1
frame_o  out  1  one-cycle pulse when the active config is (re)loaded

Behaviour:
- Reset (async, immediate): seg_o=0, sel_o=0, frame_o=0, cfg_ready=1; state OFF; slot/PWM counters 0; active and pending registers 0; pending_valid=0.
- States:
  - OFF: seg_o=0, counters held at 0. On enable=1, go to BLANK with digit0 and slot count 0.
  - BLANK: slot count < BLANK_CYCLES; seg_o=0.
  - SHOW: slot count BLANK_CYCLES..REFRESH_DIV-1. At REFRESH_DIV-1, wrap the count to 0, toggle the digit and go to BLANK.
  - enable=0 in any state: OFF on the next cycle; seg_o=0 and sel_o=0 on that cycle.
- sel_o changes only on the cycle BLANK is entered; seg_o is already 0 on that cycle.
- Frame boundary = entry into BLANK for digit0, including OFF->BLANK. At the boundary:
  - if pending_valid, copy pending to active and clear pending_valid;
  - pulse frame_o for one cycle whether or not pending_valid was set.
- Config handshake:
  - cfg_ready = !pending_valid.
  - An accept stores cfg_data into pending and sets pending_valid.
  - An accept on the boundary cycle goes to pending and is applied at the next boundary; the previous pending, if any, is applied on this boundary.
  - cfg_data is ignored when not accepted.
- Segment source: the raw flag selects raw bits or hex decode of the current digit's nibble (0-F, standard patterns).
- seg_o is registered: 1-cycle latency from state, counter or digit to pin.
- PWM:
  - 4-bit counter runs 0..14 and wraps, free-running only in SHOW; reset to 0 on BLANK entry.
  - In SHOW, seg_o = pattern when pwm_cnt < brightness, else 0.
  - brightness 0 gives dark; 15 gives always on.
  - brightness is sampled every cycle (no buffering).
- Counters are sized by $clog2(REFRESH_DIV); no overflow beyond REFRESH_DIV-1.

Decomposition:
- Package seg7_pkg:
  - typedef seg_t (logic [6:0]);
  - state enum {OFF, BLANK, SHOW};
  - constant 16-entry hex-to-segment table;
  - cfg_data field position constants.
- Sub-module seg7_hex_decode: combinational, 4-bit nibble in, seg_t out, uses the package table.
- Everything else (FSM, counters, double buffer, PWM, output registers) lives in seg7_scan_ctrl.

Test Plan (REFRESH_DIV=20, BLANK_CYCLES=4):
1. Assert ARESET mid-SHOW -> seg_o=0, sel_o=0 and cfg_ready=1 without waiting for an ACLK edge. Release with enable=0 -> seg_o stays 0.
2. Write cfg_data=16'h0021, brightness=15, enable=1 -> frame_o pulses. Digit0 shows 7'b0000110 and digit1 shows 7'b1011011. sel_o toggles every 20 cycles; seg_o=0 for the first 4 cycles of each slot.
3. Write 16'h0034 mid-frame -> display unchanged until the next frame_o, then shows 4/3. A second write while pending -> cfg_ready=0, stalled until the boundary; accepted the cycle after.
4. brightness=5 -> in each 15-cycle PWM window within SHOW, seg_o is non-zero for exactly 5 cycles. brightness=0 -> seg_o always 0.
5. Deassert enable mid-SHOW of digit1 -> seg_o=0 and sel_o=0 next cycle. Reassert -> BLANK digit0 with a frame_o pulse.
6. Raw mode cfg_data=16'h817F -> digit0 seg_o=7'h7F, digit1 seg_o=7'h01. Accept coinciding with a boundary -> applied one frame later.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit 7-segment scan controller.
// Segment order is [0]=a .. [6]=g, active-high.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Standard hex font, index = nibble value
  localparam seg_t HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam int CFG_W       = 16;
  localparam int CFG_RAW_BIT = 15;
  localparam int HEX0_LSB    = 0;
  localparam int HEX1_LSB    = 4;
  localparam int RAW0_LSB    = 0;
  localparam int RAW1_LSB    = 8;

  localparam logic [3:0] PWM_LAST = 4'd14;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup of the font pattern
  always_comb begin
    seg = HEX_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment scan controller: blanked digit slots, PWM brightness,
// and a config double buffer that only swaps at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             enable,
  input  logic [3:0]       brightness,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CFG_W-1:0] cfg_data,
  output seg_t             seg_o,
  output logic             sel_o,
  output logic             frame_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             digit_r, digit_s;
  logic [3:0]       pwm_r, pwm_s;
  logic [CFG_W-1:0] active_r, active_s;
  logic [CFG_W-1:0] pending_r, pending_s;
  logic             pend_vld_r, pend_vld_s;
  logic             boundary_s;
  logic             accept_s;
  logic [3:0]       nibble_s;
  seg_t             hex_seg_s;
  seg_t             pattern_s;
  seg_t             seg_s;

  // Scan FSM: slot counter, digit toggle, PWM counter and frame boundary detect
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    digit_s    = digit_r;
    pwm_s      = pwm_r;
    boundary_s = 1'b0;
    if (!enable) begin
      state_s = OFF;
      cnt_s   = CNT_ZERO;
      digit_s = 1'b0;
      pwm_s   = 4'd0;
    end else begin
      case (state_r)
        OFF: begin
          state_s    = BLANK;
          cnt_s      = CNT_ZERO;
          digit_s    = 1'b0;
          pwm_s      = 4'd0;
          boundary_s = 1'b1;
        end
        BLANK, SHOW: begin
          if (cnt_r == CNT_LAST) begin
            state_s    = BLANK;
            cnt_s      = CNT_ZERO;
            digit_s    = ~digit_r;
            pwm_s      = 4'd0;
            // wrapping out of digit1 starts a new frame
            boundary_s = digit_r;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
            if (cnt_s >= CNT_SHOW) begin
              state_s = SHOW;
            end else begin
              state_s = BLANK;
            end
            if (state_r == SHOW) begin
              if (pwm_r == PWM_LAST) begin
                pwm_s = 4'd0;
              end else begin
                pwm_s = pwm_r + 4'd1;
              end
            end else begin
              pwm_s = 4'd0;
            end
          end
        end
        default: begin
          state_s = OFF;
          cnt_s   = CNT_ZERO;
          digit_s = 1'b0;
          pwm_s   = 4'd0;
        end
      endcase
    end
  end

  // Config double buffer: pending swaps into active only on a frame boundary
  always_comb begin
    accept_s   = cfg_valid & cfg_ready;
    active_s   = active_r;
    pending_s  = pending_r;
    pend_vld_s = pend_vld_r;
    if (boundary_s && pend_vld_r) begin
      active_s   = pending_r;
      pend_vld_s = 1'b0;
    end else begin
      active_s   = active_r;
    end
    if (accept_s) begin
      pending_s  = cfg_data;
      pend_vld_s = 1'b1;
    end else begin
      pending_s  = pending_r;
    end
  end

  // Nibble of the digit being shown next cycle
  always_comb begin
    if (digit_s) begin
      nibble_s = active_s[HEX1_LSB +: 4];
    end else begin
      nibble_s = active_s[HEX0_LSB +: 4];
    end
  end

  seg7_hex_decode u_hex_decode (
    .nibble (nibble_s),
    .seg    (hex_seg_s)
  );

  // Pattern select (raw or hex) and PWM gating
  always_comb begin
    if (active_s[CFG_RAW_BIT]) begin
      if (digit_s) begin
        pattern_s = active_s[RAW1_LSB +: 7];
      end else begin
        pattern_s = active_s[RAW0_LSB +: 7];
      end
    end else begin
      pattern_s = hex_seg_s;
    end
    if ((state_s == SHOW) && (pwm_s < brightness)) begin
      seg_s = pattern_s;
    end else begin
      seg_s = 7'd0;
    end
  end

  // State, buffers and output pins; pins are computed from next-state so they
  // line up with the state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r    <= OFF;
      cnt_r      <= CNT_ZERO;
      digit_r    <= 1'b0;
      pwm_r      <= 4'd0;
      active_r   <= {CFG_W{1'b0}};
      pending_r  <= {CFG_W{1'b0}};
      pend_vld_r <= 1'b0;
      cfg_ready  <= 1'b1;
      seg_o      <= 7'd0;
      sel_o      <= 1'b0;
      frame_o    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      digit_r    <= digit_s;
      pwm_r      <= pwm_s;
      active_r   <= active_s;
      pending_r  <= pending_s;
      pend_vld_r <= pend_vld_s;
      cfg_ready  <= ~pend_vld_s;
      seg_o      <= seg_s;
      sel_o      <= digit_s;
      frame_o    <= boundary_s;
    end
  end

endmodule
